box_packer: RTL and testbench
=============================

Name: box_packer

Overview:
- Downstream stage of the bottle-filling controller. Consumes the one-cycle "bottle finished" pulse the filler raises when it enters its bottle-change state.
- Groups finished bottles into boxes of a configurable size and runs a timed seal phase. Waits for a fresh-box handshake from the conveyor.
- Holds the filler via hold while a box is sealed or swapped.
- Exposes live per-box and total-box counts for the seven-segment display.

Parameters:
MAX_PER_BOX, 12, largest legal bottles-per-box setting
SEAL_CYCLES, 3, cycles seal stays asserted per box (>=1)
MAX_BOXES, 999, box_count wraps to 0 after this value
BOX_W, 10, width of box_count

Ports:
clk_N  input  1  divided system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
power  input  1  machine on; low forces the idle state
per_box  input  4  requested bottles per box, sampled in CHECK
bottle_done  input  1  one-cycle pulse per finished bottle from filler
box_ready  input  1  conveyor has placed an empty box (level, sampled in SWAP)
in_box  output  4  bottles in current box
box_count  output  BOX_W  completed boxes since reset
seal  output  1  sealer drive
hold  output  1  stall request to filler
err  output  1  config error or dropped bottle

Behaviour:
- Clock and reset: one clock (clk_N); reset is synchronous and active-high (rst). All state changes on rising clk_N.
- Reset values (rst=1 at edge): state IDLE, in_box=0, box_count=0, seal=0, hold=0, err=0, limit=0, seal timer=0. rst has priority over everything.
- power=0 at an edge (rst=0): next state IDLE, in_box=0, seal=0, hold=0, err=0. box_count and limit are retained. This applies from any state, including mid-seal. A partial box is discarded.
- States: IDLE, CHECK, FILL, SEAL, SWAP.
- IDLE: if power=1, go to CHECK next cycle; otherwise stay.
- CHECK:
  - Latch limit<=per_box every cycle.
  - If per_box==0 or per_box>MAX_PER_BOX: err<=1, stay in CHECK.
  - Otherwise err<=0 and go to FILL.
  - bottle_done is ignored here.
- FILL:
  - bottle_done=1 increments in_box; the registered value is visible on the next cycle (latency 1).
  - If bottle_done=1 and in_box==limit-1: in_box<=limit, state<=SEAL, hold<=1, seal<=1, timer<=SEAL_CYCLES-1. All of these take effect in the same edge.
- SEAL:
  - seal=1 and hold=1. The timer decrements each cycle.
  - At timer==0 the next state is SWAP and seal<=0.
  - seal is high for exactly SEAL_CYCLES cycles.
- SWAP:
  - hold=1, seal=0.
  - When box_ready=1: box_count<=(box_count==MAX_BOXES)?0:box_count+1, in_box<=0, hold<=0, state<=FILL.
  - box_ready is ignored in every other state.
- Dropped bottle: bottle_done=1 while in SEAL or SWAP (including the completing SWAP cycle) sets err<=1.
  - err is sticky until rst, power=0, or re-entry to CHECK.
  - The bottle is not counted, and the state sequence is unaffected.
- Limit changes: per_box changes outside CHECK have no effect until the next power cycle.
- Width rules: in_box never exceeds limit. box_count is unsigned and wraps per MAX_BOXES, never by natural overflow.

Test Plan:
- Config check: rst, power=1, per_box=0 -> err=1, stays in CHECK. Then per_box=13 -> err=1. Then per_box=4 -> err=0 and FILL two cycles after power rises from IDLE.
- Fill/seal/swap: per_box=3, three bottle_done pulses 2 cycles apart -> in_box 1,2,3. seal=1 for exactly 3 cycles, hold=1 from the edge after the 3rd pulse. box_ready pulsed 2 cycles after seal falls -> box_count=1, in_box=0, hold=0 on the next edge.
- Dropped bottle: per_box=2, pulse bottle_done during SEAL -> err=1 sticky, in_box stays 2, box_count becomes 1 after box_ready. err clears only on power=0.
- Power-off mid-seal: per_box=2, fill, drop power in the 2nd seal cycle -> next edge seal=0, hold=0, in_box=0, box_count unchanged. Power back on -> CHECK, then FILL.
- Wrap: force 999 boxes (MAX_BOXES=999, or override to 3 for speed) -> next completed box gives box_count=0.
- Reset priority: assert rst together with box_ready in SWAP -> all outputs 0, box_count=0, state IDLE.

Source files
------------

// File: rtl/box_packer.sv
// Box packer: groups finished bottles into boxes, runs a timed seal and
// waits for the conveyor to swap in an empty box. Holds the filler meanwhile.
module box_packer #(
    parameter int MAX_PER_BOX = 12,
    parameter int SEAL_CYCLES = 3,
    parameter int MAX_BOXES   = 999,
    parameter int BOX_W       = 10
) (
    input  logic             clk_N,
    input  logic             rst,
    input  logic             power,
    input  logic [3:0]       per_box,
    input  logic             bottle_done,
    input  logic             box_ready,
    output logic [3:0]       in_box,
    output logic [BOX_W-1:0] box_count,
    output logic             seal,
    output logic             hold,
    output logic             err
);
    localparam int TW = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, FILL, SEAL, SWAP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       in_box_q, in_box_d;
    logic [3:0]       limit_q, limit_d;
    logic [BOX_W-1:0] box_count_q, box_count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;

    logic cfg_bad, last_bottle;
    assign cfg_bad     = (per_box == 4'd0) || (per_box > 4'(MAX_PER_BOX));
    assign last_bottle = bottle_done && (in_box_q == limit_q - 4'd1);

    always_ff @(posedge clk_N) begin
        if (rst) begin
            state_q     <= IDLE;
            in_box_q    <= '0;
            limit_q     <= '0;
            box_count_q <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_box_q    <= in_box_d;
            limit_q     <= limit_d;
            box_count_q <= box_count_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!power) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CHECK;
                CHECK:   if (!cfg_bad) state_d = FILL;
                FILL:    if (last_bottle) state_d = SEAL;
                SEAL:    if (timer_q == '0) state_d = SWAP;
                SWAP:    if (box_ready) state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next-state; power loss discards any partial box but keeps totals.
    always_comb begin
        in_box_d    = in_box_q;
        limit_d     = limit_q;
        box_count_d = box_count_q;
        timer_d     = timer_q;
        err_d       = err_q;
        if (!power) begin
            in_box_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                CHECK: begin
                    limit_d = per_box;
                    err_d   = cfg_bad;
                end
                FILL: begin
                    if (bottle_done) in_box_d = in_box_q + 4'd1;
                    if (last_bottle) timer_d = TW'(SEAL_CYCLES - 1);
                end
                SEAL: begin
                    if (timer_q != '0) timer_d = timer_q - TW'(1);
                    if (bottle_done) err_d = 1'b1;
                end
                SWAP: begin
                    if (bottle_done) err_d = 1'b1;
                    if (box_ready) begin
                        in_box_d    = '0;
                        box_count_d = (box_count_q == BOX_W'(MAX_BOXES)) ? '0
                                                                         : box_count_q + BOX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_box    = in_box_q;
        box_count = box_count_q;
        err       = err_q;
        seal      = (state_q == SEAL);
        hold      = (state_q == SEAL) || (state_q == SWAP);
    end
endmodule

// File: tb/tb_box_packer.sv
// Bench for box_packer: directed scenarios then random traffic, every cycle
// compared against a phase-level reference model.
module tb_box_packer;
    localparam int MAX_PER_BOX = 12;
    localparam int SEAL_CYCLES = 3;
    localparam int MAX_BOXES   = 3;
    localparam int BOX_W       = 10;

    logic             clk_N = 1'b0;
    logic             rst = 1'b1, power = 1'b0, bottle_done = 1'b0, box_ready = 1'b0;
    logic [3:0]       per_box = 4'd0;
    logic [3:0]       in_box;
    logic [BOX_W-1:0] box_count;
    logic             seal, hold, err;

    box_packer #(.MAX_PER_BOX(MAX_PER_BOX), .SEAL_CYCLES(SEAL_CYCLES),
                 .MAX_BOXES(MAX_BOXES), .BOX_W(BOX_W)) dut (
        .clk_N(clk_N), .rst(rst), .power(power), .per_box(per_box),
        .bottle_done(bottle_done), .box_ready(box_ready), .in_box(in_box),
        .box_count(box_count), .seal(seal), .hold(hold), .err(err)
    );

    always #5 clk_N = ~clk_N;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 off, 1 config, 2 filling, 3 sealing, 4 awaiting box
    int m_phase = 0, m_in = 0, m_boxes = 0, m_limit = 0, m_seal_left = 0;
    bit m_err = 0;

    task automatic model_step(input bit r, input bit pw, input int pb, input bit bd, input bit br);
        if (r) begin
            m_phase = 0; m_in = 0; m_boxes = 0; m_limit = 0; m_seal_left = 0; m_err = 0;
        end else if (!pw) begin
            m_phase = 0; m_in = 0; m_err = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_limit = pb;
                    if (pb < 1 || pb > MAX_PER_BOX) m_err = 1;
                    else begin m_err = 0; m_phase = 2; end
                end
                2: if (bd) begin
                    m_in++;
                    if (m_in == m_limit) begin m_phase = 3; m_seal_left = SEAL_CYCLES; end
                end
                3: begin
                    if (bd) m_err = 1;
                    m_seal_left--;
                    if (m_seal_left == 0) m_phase = 4;
                end
                default: begin
                    if (bd) m_err = 1;
                    if (br) begin m_boxes = (m_boxes + 1) % (MAX_BOXES + 1); m_in = 0; m_phase = 2; end
                end
            endcase
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk_N);
        model_step(rst, power, int'(per_box), bottle_done, box_ready);
        #1;
        chk("in_box", 32'(in_box), 32'(m_in));
        chk("box_count", 32'(box_count), 32'(m_boxes));
        chk("seal", 32'(seal), 32'(m_phase == 3));
        chk("hold", 32'(hold), 32'(m_phase == 3 || m_phase == 4));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic step(input bit bd, input bit br);
        bottle_done = bd; box_ready = br;
        cycle();
        bottle_done = 1'b0; box_ready = 1'b0;
    endtask

    task automatic power_on(input logic [3:0] pb);
        power = 1'b0; step(0, 0);
        power = 1'b1; per_box = pb; step(0, 0); step(0, 0);
    endtask

    task automatic fill_and_seal(input int n);
        for (int i = 0; i < n; i++) step(1, 0);
        for (int i = 0; i < SEAL_CYCLES; i++) step(0, 0);
    endtask

    int seal_cnt;

    initial begin
        rst = 1'b1; step(0, 0); step(0, 0);
        chk("rst_box_count", 32'(box_count), 0);
        chk("rst_hold", 32'(hold), 0);
        rst = 1'b0;

        // configuration checks
        power = 1'b1; per_box = 4'd0; step(0, 0); step(0, 0);
        chk("cfg_zero_err", 32'(err), 1);
        per_box = 4'd13; step(0, 0);
        chk("cfg_13_err", 32'(err), 1);
        per_box = 4'd4; step(0, 0);
        chk("cfg_4_err", 32'(err), 0);

        // fill / seal / swap with three bottles
        power_on(4'd3);
        step(1, 0); step(0, 0); chk("fill_1", 32'(in_box), 1);
        step(1, 0); step(0, 0); chk("fill_2", 32'(in_box), 2);
        step(1, 0);
        chk("fill_3", 32'(in_box), 3);
        chk("hold_after_3rd", 32'(hold), 1);
        seal_cnt = int'(seal);
        for (int i = 0; i < 5; i++) begin step(0, 0); seal_cnt += int'(seal); end
        chk("seal_len", 32'(seal_cnt), 3);
        step(0, 1);
        chk("swap_box_count", 32'(box_count), 1);
        chk("swap_hold", 32'(hold), 0);

        // dropped bottle during seal
        power_on(4'd2);
        step(1, 0); step(1, 0); step(1, 0);
        chk("drop_err", 32'(err), 1);
        chk("drop_in_box", 32'(in_box), 2);
        step(0, 0); step(0, 0); step(0, 1);
        chk("drop_box_count", 32'(box_count), 2);
        chk("drop_err_sticky", 32'(err), 1);
        power = 1'b0; step(0, 0);
        chk("drop_err_clear", 32'(err), 0);

        // power loss in the second seal cycle
        power_on(4'd2);
        step(1, 0); step(1, 0); step(0, 0);
        power = 1'b0; step(0, 0);
        chk("poff_seal", 32'(seal), 0);
        chk("poff_in_box", 32'(in_box), 0);
        chk("poff_box_count", 32'(box_count), 2);
        power = 1'b1; step(0, 0); step(0, 0);

        // wrap at MAX_BOXES
        fill_and_seal(2); step(0, 1);
        chk("wrap_at_max", 32'(box_count), 3);
        fill_and_seal(2); step(0, 1);
        chk("wrap_zero", 32'(box_count), 0);

        // reset wins over box_ready in SWAP
        fill_and_seal(2);
        rst = 1'b1; step(0, 1); rst = 1'b0;
        chk("rstprio_box_count", 32'(box_count), 0);
        chk("rstprio_hold", 32'(hold), 0);

        // random traffic
        power = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) power = ~power;
            if ($urandom_range(0, 19) == 0) per_box = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
